// File: rtl/comp_window_ctrl.sv
// ---------------------------------------------------------------------------
// comp_window_ctrl
// Sequencer that uses the NPU auto comparator as a running unsigned-max
// accumulator. It reads a window of 16-bit words from a local buffer and
// streams each word into the comparator's In_Read port. The comparator's
// registered Output goes back into its In_COMP port. When the window is
// finished, the sequencer captures the final maximum and pulses done.
//
// Optional build macro: COMP_ARGMAX_EN
//   When this macro is defined, the block adds result_idx. result_idx is the
//   window offset of the last occurrence of the maximum.
//
// Ports
//   CLK, RST_COMP      clock, asynchronous active-high reset
//   start              one-cycle request, only sampled while idle
//   base_addr, win_len window start address and length, latched on start
//   mem_rd, mem_addr   buffer read strobe and address (addresses wrap)
//   mem_rdata          buffer data, valid one cycle after mem_rd
//   cmp_rst, cmp_en    comparator clear and enable
//   cmp_in_read        comparator In_Read (buffer data pass-through)
//   cmp_in_comp        comparator In_COMP (comparator output fed back)
//   cmp_out            comparator registered Output
//   busy               high from the clear cycle through the capture cycle
//   done               one-cycle completion pulse
//   result             captured window maximum
//   result_valid       high from done until the next accepted start
//   result_idx         (COMP_ARGMAX_EN only) offset of the maximum
// ---------------------------------------------------------------------------
module comp_window_ctrl #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              CLK,
    input  logic              RST_COMP,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  win_len,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    output logic              cmp_rst,
    output logic              cmp_en,
    output logic [15:0]       cmp_in_read,
    output logic [15:0]       cmp_in_comp,
    input  logic [15:0]       cmp_out,
    output logic              busy,
    output logic              done,
    output logic [15:0]       result,
    output logic              result_valid
`ifdef COMP_ARGMAX_EN
    ,
    output logic [LEN_W-1:0]  result_idx
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_RUN  = 3'd2,
        S_CAPT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_rd_left;   // reads still to issue after the current one
`ifdef COMP_ARGMAX_EN
    logic [LEN_W-1:0]  r_en_cnt;    // offset of the word the comparator sees now
    logic [LEN_W-1:0]  r_track;     // offset of the latest maximum so far
`endif

    // The comparator takes buffer data directly and gets its own output fed back.
    assign cmp_in_read = mem_rdata;
    assign cmp_in_comp = cmp_out;

    // Window sequencer: state, read issue, accumulate enable and result capture.
    always_ff @(posedge CLK or posedge RST_COMP) begin
        if (RST_COMP) begin
            r_state      <= S_IDLE;
            r_base       <= '0;
            r_len        <= '0;
            r_rd_left    <= '0;
            mem_rd       <= 1'b0;
            mem_addr     <= '0;
            cmp_rst      <= 1'b0;
            cmp_en       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= 16'h0000;
            result_valid <= 1'b0;
`ifdef COMP_ARGMAX_EN
            r_en_cnt     <= '0;
            r_track      <= '0;
            result_idx   <= '0;
`endif
        end else begin
            // The enable trails the read strobe by exactly one cycle. This matches
            // the one-cycle buffer latency. The enable stays contiguous because
            // the reads are contiguous.
            cmp_en <= mem_rd;
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (win_len == '0) begin
                            // An empty window has max 0. Skip the comparator completely.
                            result       <= 16'h0000;
                            result_valid <= 1'b1;
                            done         <= 1'b1;
`ifdef COMP_ARGMAX_EN
                            result_idx   <= '0;
`endif
                            r_state      <= S_DONE;
                        end else begin
                            r_base       <= base_addr;
                            r_len        <= win_len;
                            result_valid <= 1'b0;
                            cmp_rst      <= 1'b1;
                            busy         <= 1'b1;
                            r_state      <= S_CLR;
                        end
                    end
                end
                S_CLR: begin
                    cmp_rst   <= 1'b0;
                    mem_rd    <= 1'b1;
                    mem_addr  <= r_base;
                    r_rd_left <= r_len - LEN_W'(1);
`ifdef COMP_ARGMAX_EN
                    r_en_cnt  <= '0;
                    r_track   <= '0;
`endif
                    r_state   <= S_RUN;
                end
                S_RUN: begin
                    if (mem_rd) begin
                        if (r_rd_left == '0) begin
                            mem_rd <= 1'b0;
                        end else begin
                            mem_addr  <= mem_addr + ADDR_W'(1);
                            r_rd_left <= r_rd_left - LEN_W'(1);
                        end
                    end
                    if (cmp_en) begin
`ifdef COMP_ARGMAX_EN
                        r_en_cnt <= r_en_cnt + LEN_W'(1);
                        // Use the same tie rule as the comparator, so the latest equal word wins.
                        if (mem_rdata >= cmp_out) begin
                            r_track <= r_en_cnt;
                        end
`endif
                        // The last accumulate cycle is the one where no read is outstanding.
                        if (!mem_rd) begin
                            r_state <= S_CAPT;
                        end
                    end
                end
                S_CAPT: begin
                    result       <= cmp_out;
`ifdef COMP_ARGMAX_EN
                    result_idx   <= r_track;
`endif
                    result_valid <= 1'b1;
                    done         <= 1'b1;
                    busy         <= 1'b0;
                    r_state      <= S_DONE;
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    mem_rd  <= 1'b0;
                    cmp_rst <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comp_window_ctrl.sv
module tb_comp_window_ctrl;

    logic        CLK          = 1'b0;
    logic        RST_COMP     = 1'b0;
    logic        start        = 1'b0;
    logic [7:0]  base_addr    = 8'h00;
    logic [7:0]  win_len      = 8'h00;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata    = 16'h0000;
    logic        cmp_rst;
    logic        cmp_en;
    logic [15:0] cmp_in_read;
    logic [15:0] cmp_in_comp;
    logic [15:0] cmp_out      = 16'h0000;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        result_valid;
`ifdef COMP_ARGMAX_EN
    logic [7:0]  result_idx;
`endif

    logic [15:0] mem [0:255];
    int          checks = 0;
    int          errors = 0;
    bit          chk_on = 1'b0;

    comp_window_ctrl #(.ADDR_W(8), .LEN_W(8)) dut (
        .CLK(CLK), .RST_COMP(RST_COMP), .start(start),
        .base_addr(base_addr), .win_len(win_len),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .cmp_rst(cmp_rst), .cmp_en(cmp_en),
        .cmp_in_read(cmp_in_read), .cmp_in_comp(cmp_in_comp), .cmp_out(cmp_out),
        .busy(busy), .done(done), .result(result), .result_valid(result_valid)
`ifdef COMP_ARGMAX_EN
        , .result_idx(result_idx)
`endif
    );

    always #5 CLK = ~CLK;

    // Local buffer: data appears one cycle after the read strobe.
    always @(posedge CLK) begin
        if (mem_rd === 1'b1) mem_rdata <= mem[mem_addr];
    end

    // Auto comparator: clear, otherwise the registered max when enabled, else 0.
    always @(posedge CLK) begin
        if (cmp_rst === 1'b1)     cmp_out <= 16'h0000;
        else if (cmp_en === 1'b1) cmp_out <= (cmp_in_read >= cmp_in_comp) ? cmp_in_read : cmp_in_comp;
        else                      cmp_out <= 16'h0000;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] win_max(input logic [7:0] b, input logic [7:0] n);
        logic [15:0] mx = 16'h0000;
        for (int i = 0; i < int'(n); i++) begin
            if (mem[8'(int'(b) + i)] >= mx) mx = mem[8'(int'(b) + i)];
        end
        return mx;
    endfunction

    function automatic int win_idx(input logic [7:0] b, input logic [7:0] n);
        logic [15:0] mx = 16'h0000;
        int ix = 0;
        for (int i = 0; i < int'(n); i++) begin
            if (mem[8'(int'(b) + i)] >= mx) begin
                mx = mem[8'(int'(b) + i)];
                ix = i;
            end
        end
        return ix;
    endfunction

    // The reference model tracks the phase: the cycle count since the accepted start.
    // The expected outputs are arithmetic in that phase.
    bit          m_act   = 1'b0;
    int          m_p     = 0;
    int          m_n     = 0;
    int          m_dp    = 0;
    logic [7:0]  m_base  = 8'h00;
    logic [15:0] m_max   = 16'h0000;
    logic [15:0] m_res   = 16'h0000;
    int          m_idx   = 0;
    int          m_ridx  = 0;
    bit          m_valid = 1'b0;

    // Update the model phase at each clock edge. Reset is asynchronous.
    always @(posedge CLK or posedge RST_COMP) begin
        if (RST_COMP) begin
            m_act   <= 1'b0;
            m_valid <= 1'b0;
            m_res   <= 16'h0000;
            m_ridx  <= 0;
        end else if (m_act) begin
            if (m_p == m_dp) begin
                m_act <= 1'b0;
            end else begin
                m_p <= m_p + 1;
                if (m_p + 1 == m_dp) begin
                    m_res   <= m_max;
                    m_ridx  <= m_idx;
                    m_valid <= 1'b1;
                end
            end
        end else if (start === 1'b1) begin
            m_act  <= 1'b1;
            m_p    <= 1;
            m_n    <= int'(win_len);
            m_base <= base_addr;
            m_dp   <= (win_len == 8'd0) ? 1 : int'(win_len) + 4;
            m_max  <= win_max(base_addr, win_len);
            m_idx  <= win_idx(base_addr, win_len);
            if (win_len == 8'd0) begin
                m_res   <= 16'h0000;
                m_ridx  <= 0;
                m_valid <= 1'b1;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    // On every falling edge, compare each DUT output with the model.
    always @(negedge CLK) begin
        if (chk_on && RST_COMP === 1'b0) begin
            chk("mem_rd",  32'(mem_rd),  32'(m_act && m_p >= 2 && m_p <= m_n + 1));
            chk("cmp_rst", 32'(cmp_rst), 32'(m_act && m_n > 0 && m_p == 1));
            chk("cmp_en",  32'(cmp_en),  32'(m_act && m_p >= 3 && m_p <= m_n + 2));
            chk("busy",    32'(busy),    32'(m_act && m_n > 0 && m_p <= m_n + 3));
            chk("done",    32'(done),    32'(m_act && m_p == m_dp));
            if (m_act && m_p >= 2 && m_p <= m_n + 1)
                chk("mem_addr", 32'(mem_addr), 32'((int'(m_base) + m_p - 2) & 255));
            chk("result",       32'(result),       32'(m_res));
            chk("result_valid", 32'(result_valid), 32'(m_valid));
            chk("cmp_in_read",  32'(cmp_in_read),  32'(mem_rdata));
            chk("cmp_in_comp",  32'(cmp_in_comp),  32'(cmp_out));
`ifdef COMP_ARGMAX_EN
            chk("result_idx",   32'(result_idx),   32'(m_ridx));
`endif
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_rd"},       32'(mem_rd),       32'h0);
        chk({tag, "_mem_addr"},     32'(mem_addr),     32'h0);
        chk({tag, "_cmp_rst"},      32'(cmp_rst),      32'h0);
        chk({tag, "_cmp_en"},       32'(cmp_en),       32'h0);
        chk({tag, "_busy"},         32'(busy),         32'h0);
        chk({tag, "_done"},         32'(done),         32'h0);
        chk({tag, "_result"},       32'(result),       32'h0);
        chk({tag, "_result_valid"}, 32'(result_valid), 32'h0);
`ifdef COMP_ARGMAX_EN
        chk({tag, "_result_idx"},   32'(result_idx),   32'h0);
`endif
    endtask

    // Pulse start and wait, with a cycle limit, for done. cyc is the cycle number
    // of done, counted from the edge that samples start. poke re-raises start in
    // that cycle. dpoke raises start during the done cycle.
    task automatic run_window(input logic [7:0] b, input logic [7:0] n,
                              input int poke, input bit dpoke, output int cyc);
        int cnt;
        bit fin;
        @(posedge CLK); #1;
        base_addr = b;
        win_len   = n;
        start     = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        cnt   = 1;
        fin   = 1'b0;
        while (!fin) begin
            @(negedge CLK);
            if (done === 1'b1) begin
                fin = 1'b1;
            end else if (cnt >= 400) begin
                checks++;
                errors++;
                $display("FAIL done_timeout: got no done after %0d cycles, required done", cnt);
                fin = 1'b1;
            end else begin
                @(posedge CLK); #1;
                cnt++;
                start = (cnt == poke);
            end
        end
        start = 1'b0;
        if (dpoke) begin
            start = 1'b1;
            @(posedge CLK); #1;
            start = 1'b0;
        end
        cyc = cnt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [7:0] b;
        logic [7:0] n;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

        // Reset, then idle with no start.
        #2 RST_COMP = 1'b1;
        repeat (3) @(posedge CLK);
        #1 check_all_zero("reset");
        RST_COMP = 1'b0;
        chk_on   = 1'b1;
        repeat (10) @(posedge CLK);
        #1 check_all_zero("idle");

        // Basic window 3,9,2,7 at address 0x10.
        mem[8'h10] = 16'd3; mem[8'h11] = 16'd9; mem[8'h12] = 16'd2; mem[8'h13] = 16'd7;
        run_window(8'h10, 8'd4, 0, 1'b0, cyc);
        chk("t1_done_cycle", 32'(cyc), 32'd8);
        chk("t1_result", 32'(result), 32'd9);
        chk("t1_valid", 32'(result_valid), 32'd1);
`ifdef COMP_ARGMAX_EN
        chk("t1_idx", 32'(result_idx), 32'd1);
`endif

        // Address wrap from 0xFE.
        mem[8'hFE] = 16'h8000; mem[8'hFF] = 16'hFFFF; mem[8'h00] = 16'h0001; mem[8'h01] = 16'h0000;
        run_window(8'hFE, 8'd4, 0, 1'b0, cyc);
        chk("t2_result", 32'(result), 32'h0000FFFF);
`ifdef COMP_ARGMAX_EN
        chk("t2_idx", 32'(result_idx), 32'd1);
`endif

        // Empty window.
        run_window(8'h30, 8'd0, 0, 1'b0, cyc);
        chk("t3_result", 32'(result), 32'd0);
        chk("t3_valid", 32'(result_valid), 32'd1);

        // Tie 5,9,9,1 with start pulsed again during RUN.
        mem[8'h50] = 16'd5; mem[8'h51] = 16'd9; mem[8'h52] = 16'd9; mem[8'h53] = 16'd1;
        run_window(8'h50, 8'd4, 4, 1'b1, cyc);
        chk("t4_result", 32'(result), 32'd9);
        chk("t4_done_cycle", 32'(cyc), 32'd8);
`ifdef COMP_ARGMAX_EN
        chk("t4_idx", 32'(result_idx), 32'd2);
`endif
        repeat (3) @(posedge CLK);
        #1 chk("t4_stays_idle", 32'(busy), 32'd0);

        // Reset in cycle 4 of a length-8 window, then a fresh length-2 window.
        for (int i = 0; i < 8; i++) mem[8'h60 + i] = 16'(100 + i);
        @(posedge CLK); #1;
        base_addr = 8'h60; win_len = 8'd8; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST_COMP = 1'b1;
        #1 check_all_zero("midreset");
        @(posedge CLK); #1;
        RST_COMP = 1'b0;
        mem[8'h20] = 16'd4; mem[8'h21] = 16'd6;
        run_window(8'h20, 8'd2, 0, 1'b0, cyc);
        chk("t5_result", 32'(result), 32'd6);
        chk("t5_done_cycle", 32'(cyc), 32'd6);
`ifdef COMP_ARGMAX_EN
        chk("t5_idx", 32'(result_idx), 32'd1);
`endif

        // Random windows, including ties, wrapping, empty windows, ignored starts and back-to-back runs.
        for (int t = 0; t < 40; t++) begin
            b = 8'($urandom);
            n = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < int'(n); i++) mem[8'(int'(b) + i)] = 16'($urandom_range(0, 3));
            end else begin
                for (int i = 0; i < int'(n); i++) mem[8'(int'(b) + i)] = 16'($urandom);
            end
            run_window(b, n, $urandom_range(0, int'(n) + 3), 1'($urandom_range(0, 1)), cyc);
            chk("rnd_done_cycle", 32'(cyc), (n == 8'd0) ? 32'd1 : 32'(int'(n) + 4));
        end

        repeat (4) @(posedge CLK);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
